// File: rtl/seq_mult_4bit_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
//   state_e : FSM encoding (IDLE / CALC / DONE)
//   cnt_w() : iteration counter width for a given operand width, never below 1
package seq_mult_4bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/seq_mult_4bit_adder_nbit.sv
// WIDTH-bit combinational ripple adder with carry-out.
//   i_a, i_b : addends
//   o_sum    : low WIDTH bits of i_a + i_b
//   o_cout   : carry out of the MSB
module adder_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_cout = w_full[WIDTH];

endmodule

// File: rtl/seq_mult_4bit.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready/a/b: operand handshake (accepted only in IDLE)
//   out_valid/out_ready  : result handshake (product held while DONE)
//   product              : a*b, 2*WIDTH bits, holds last completed result
//   busy                 : high in CALC or DONE
module seq_mult_4bit
  import seq_mult_4bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc_hi;
  logic [CNT_W-1:0] r_count;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0] w_pp;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic             w_last;
  logic             w_accept;

  // Partial product is either the multiplicand or zero, picked by the LSB
  // of the (shifting) multiplier.
  assign w_pp = r_mplier[0] ? r_mcand : '0;

  adder_nbit #(.WIDTH(WIDTH)) u_add (
    .i_a   (r_acc_hi),
    .i_b   (w_pp),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // {cout, sum, mplier} >> 1: the carry lands in the accumulator MSB and the
  // sum LSB drops into the multiplier MSB, which becomes the product low half.
  assign w_acc_nxt    = {w_cout, w_sum[WIDTH-1:1]};
  assign w_mplier_nxt = {w_sum[0], r_mplier[WIDTH-1:1]};
  assign w_last       = (r_count == CNT_W'(WIDTH - 1));
  assign w_accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        // rst_n gating keeps in_ready low while reset is held.
        in_ready = rst_n;
        if (in_valid && rst_n) w_state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc_hi  <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc_hi <= '0;
            r_count  <= '0;
          end
        end
        CALC: begin
          r_acc_hi <= w_acc_nxt;
          r_mplier <= w_mplier_nxt;
          r_count  <= r_count + CNT_W'(1);
          // Result register only updates on entry to DONE, so consumers
          // never see a partially accumulated value.
          if (w_last) r_product <= {w_acc_nxt, w_mplier_nxt};
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule
